// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the MIPS register file and its dump engine.
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_LOAD = 2'd1,
        DUMP_SEND = 2'd2
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_seq.sv
// Dump engine: walks the register indices, snapshots each word one cycle
// before presenting it, and holds it until the consumer accepts it.
module regfile_dump_seq
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] idx_o,
    output logic              last_o,
    output logic              busy_o
);

    // One extra counter bit keeps the final index distinct from a wrapped zero.
    localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

    dump_state_e       state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic              last_q, last_d;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        word_idx_d = word_idx_q;
        last_d     = last_q;
        case (state_q)
            DUMP_IDLE: begin
                if (start_i) begin
                    idx_d   = '0;
                    state_d = DUMP_LOAD;
                end
            end
            DUMP_LOAD: begin
                data_d     = rd_data_i;
                word_idx_d = idx_q[ADDR_W-1:0];
                last_d     = (idx_q == LAST_IDX);
                state_d    = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (ready_i) begin
                    if (last_q) begin
                        state_d = DUMP_IDLE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = DUMP_LOAD;
                    end
                end
            end
            default: state_d = DUMP_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DUMP_IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            word_idx_q <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            word_idx_q <= word_idx_d;
            last_q     <= last_d;
        end
    end

    assign rd_addr_o = idx_q[ADDR_W-1:0];
    assign valid_o   = (state_q == DUMP_SEND);
    assign busy_o    = (state_q != DUMP_IDLE);
    assign data_o    = data_q;
    assign idx_o     = word_idx_q;
    assign last_o    = last_q;

endmodule

// File: rtl/regfile_dump.sv
// MIPS register file: two bypassed combinational read ports, one write port,
// optional hard-wired zero register, and a handshaked sequential dump port.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              ENABLE,
    input  logic [ADDR_W-1:0] I_RS_ADDR,
    input  logic [ADDR_W-1:0] I_RT_ADDR,
    input  logic [ADDR_W-1:0] I_WR_ADDR,
    input  logic [DATA_W-1:0] I_WR_DATA,
    input  logic              I_WR_EN,
    output logic [DATA_W-1:0] O_RS_DATA,
    output logic [DATA_W-1:0] O_RT_DATA,
    input  logic              I_DUMP_START,
    input  logic              I_DUMP_READY,
    output logic              O_DUMP_VALID,
    output logic [DATA_W-1:0] O_DUMP_DATA,
    output logic [ADDR_W-1:0] O_DUMP_IDX,
    output logic              O_DUMP_LAST,
    output logic              O_DUMP_BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_fire;
    logic              wr_commit;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_rd_data;

    assign wr_fire   = I_WR_EN && ENABLE;
    assign wr_commit = wr_fire && !((ZERO_REG != 0) && (I_WR_ADDR == '0));

    // NOTE: every register must clear on reset, so the array is built from resettable flops rather than a RAM macro.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_commit) begin
            mem_q[I_WR_ADDR] <= I_WR_DATA;
        end
    end

    // A write landing this cycle is forwarded so WB->ID sees write-before-read.
    function automatic logic [DATA_W-1:0] bypass_read(input logic [ADDR_W-1:0] addr);
        if ((ZERO_REG != 0) && (addr == '0)) begin
            return '0;
        end
        if (wr_fire && (I_WR_ADDR == addr)) begin
            return I_WR_DATA;
        end
        return mem_q[addr];
    endfunction

    always_comb begin
        O_RS_DATA    = bypass_read(I_RS_ADDR);
        O_RT_DATA    = bypass_read(I_RT_ADDR);
        dump_rd_data = bypass_read(dump_addr);
    end

    regfile_dump_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .start_i   (I_DUMP_START),
        .ready_i   (I_DUMP_READY),
        .rd_data_i (dump_rd_data),
        .rd_addr_o (dump_addr),
        .valid_o   (O_DUMP_VALID),
        .data_o    (O_DUMP_DATA),
        .idx_o     (O_DUMP_IDX),
        .last_o    (O_DUMP_LAST),
        .busy_o    (O_DUMP_BUSY)
    );

endmodule

// File: tb/tb_regfile_dump.sv
// Randomised bench for regfile_dump: a register-array reference model with a
// timing-level dump model, plus directed literal checks on key scenarios.
module tb_regfile_dump;

    localparam int N = 32;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        wr_en = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    logic [31:0] rs_data, rt_data, d_data;
    logic [4:0]  d_idx;
    logic        d_valid, d_last, d_busy;
    logic [31:0] nz_rs_data, nz_rt_data, nz_d_data;
    logic [4:0]  nz_d_idx;
    logic        nz_d_valid, nz_d_last, nz_d_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_dump dut (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(enable),
        .I_RS_ADDR(rs_addr), .I_RT_ADDR(rt_addr), .I_WR_ADDR(wr_addr),
        .I_WR_DATA(wr_data), .I_WR_EN(wr_en),
        .O_RS_DATA(rs_data), .O_RT_DATA(rt_data),
        .I_DUMP_START(start), .I_DUMP_READY(ready),
        .O_DUMP_VALID(d_valid), .O_DUMP_DATA(d_data), .O_DUMP_IDX(d_idx),
        .O_DUMP_LAST(d_last), .O_DUMP_BUSY(d_busy)
    );

    regfile_dump #(.ZERO_REG(0)) dut_nz (
        .CLK(clk), .RESET_N(rst_n), .ENABLE(enable),
        .I_RS_ADDR(rs_addr), .I_RT_ADDR(rt_addr), .I_WR_ADDR(wr_addr),
        .I_WR_DATA(wr_data), .I_WR_EN(wr_en),
        .O_RS_DATA(nz_rs_data), .O_RT_DATA(nz_rt_data),
        .I_DUMP_START(start), .I_DUMP_READY(ready),
        .O_DUMP_VALID(nz_d_valid), .O_DUMP_DATA(nz_d_data), .O_DUMP_IDX(nz_d_idx),
        .O_DUMP_LAST(nz_d_last), .O_DUMP_BUSY(nz_d_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m1: zero-register build, m0: plain build. Contents are "after this cycle's write".
    logic [31:0] m1 [N];
    logic [31:0] m0 [N];
    bit          busy_m, pres_m, was_busy;
    int          load_at, nxt, cyc;
    word_t       w_m;
    logic [31:0] w0_m;
    word_t       got_q [$];

    function automatic logic [31:0] m1_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : m1[a];
    endfunction

    always begin
        @(negedge clk);
        #3;
        if (d_valid && ready && rst_n) got_q.push_back('{idx: d_idx, data: d_data, last: d_last});
        if (!rst_n) begin
            foreach (m1[i]) begin
                m1[i] = '0;
                m0[i] = '0;
            end
            busy_m = 1'b0;
            pres_m = 1'b0;
            check("rst_valid", 32'(d_valid), 0);
            check("rst_busy", 32'(d_busy), 0);
            check("rst_data", d_data, 0);
            check("rst_idx", 32'(d_idx), 0);
            check("rst_last", 32'(d_last), 0);
            check("rst_nz_valid", 32'(nz_d_valid), 0);
        end else begin
            if (wr_en && enable) begin
                m0[wr_addr] = wr_data;
                if (wr_addr != 5'd0) m1[wr_addr] = wr_data;
            end
            check("rs_data", rs_data, m1_rd(rs_addr));
            check("rt_data", rt_data, m1_rd(rt_addr));
            check("nz_rs_data", nz_rs_data, m0[rs_addr]);
            check("nz_rt_data", nz_rt_data, m0[rt_addr]);
            check("dump_valid", 32'(d_valid), 32'(pres_m));
            check("dump_busy", 32'(d_busy), 32'(busy_m));
            check("nz_dump_valid", 32'(nz_d_valid), 32'(pres_m));
            check("nz_dump_busy", 32'(nz_d_busy), 32'(busy_m));
            if (pres_m) begin
                check("dump_data", d_data, w_m.data);
                check("dump_idx", 32'(d_idx), 32'(w_m.idx));
                check("dump_last", 32'(d_last), 32'(w_m.last));
                check("nz_dump_data", nz_d_data, w0_m);
                check("nz_dump_idx", 32'(nz_d_idx), 32'(w_m.idx));
            end
            // Dump timing: a word is snapshotted one cycle after START or after
            // the previous word's handshake, and presented from the next cycle on.
            was_busy = busy_m;
            if (pres_m && ready) begin
                pres_m = 1'b0;
                if (w_m.last) begin
                    busy_m = 1'b0;
                end else begin
                    nxt     = int'(w_m.idx) + 1;
                    load_at = cyc + 1;
                end
            end else if (busy_m && !pres_m && cyc == load_at) begin
                w_m.idx  = 5'(nxt);
                w_m.data = m1_rd(5'(nxt));
                w_m.last = (nxt == N - 1);
                w0_m     = m0[nxt];
                pres_m   = 1'b1;
            end
            if (!was_busy && start) begin
                busy_m  = 1'b1;
                nxt     = 0;
                load_at = cyc + 1;
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        ready = 1'b1;
        start = 1'b0;
        wr_en = 1'b0;
        while (d_busy && n < budget) begin
            tick();
            n++;
        end
        check("idle_reached", 32'(d_busy), 0);
    endtask

    task automatic wait_words(input int count, input int budget);
        int n = 0;
        while (got_q.size() < count && n < budget) begin
            tick();
            n++;
        end
        check("words_collected", got_q.size(), count);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

    initial begin
        int n;
        bit w20, w25;

        // 1. reset, then every address reads zero
        repeat (3) tick();
        rst_n = 1'b1;
        for (int a = 0; a < N; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(N - 1 - a);
            #1;
            check("post_rst_rs", rs_data, 0);
            check("post_rst_rt", rt_data, 0);
            tick();
        end
        check("post_rst_valid", 32'(d_valid), 0);
        check("post_rst_busy", 32'(d_busy), 0);

        // 2. write with bypass, then a write blocked by ENABLE=0
        enable = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs_addr = 5'd5;
        #1 check("bypass_r5", rs_data, 32'hDEADBEEF);
        tick();
        wr_en = 1'b0;
        #1 check("stored_r5", rs_data, 32'hDEADBEEF);
        tick();
        enable = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; rs_addr = 5'd7;
        #1 check("disabled_bypass_r7", rs_data, 0);
        tick();
        enable = 1'b1; wr_en = 1'b0;
        #1 check("disabled_write_r7", rs_data, 0);
        tick();

        // 3. zero register in both builds
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rs_addr = 5'd0;
        #1;
        check("zero_reg_bypass", rs_data, 0);
        check("nz_r0_bypass", nz_rs_data, 32'h12345678);
        tick();
        wr_en = 1'b0;
        #1;
        check("zero_reg_read", rs_data, 0);
        check("nz_r0_read", nz_rs_data, 32'h12345678);
        tick();

        // 4. full dump with READY held high
        for (int i = 0; i < N; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 32'(i * 32'h11);
            tick();
        end
        wr_en = 1'b0;
        got_q.delete();
        ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        check("load_cycle_valid", 32'(d_valid), 0);
        check("load_cycle_busy", 32'(d_busy), 1);
        tick();
        #1;
        check("first_word_valid", 32'(d_valid), 1);
        check("first_word_idx", 32'(d_idx), 0);
        wait_words(N, 200);
        #1 check("busy_after_last", 32'(d_busy), 0);
        for (int i = 0; i < got_q.size(); i++) begin
            check("full_idx", 32'(got_q[i].idx), 32'(i));
            check("full_data", got_q[i].data, 32'(i * 32'h11));
            check("full_last", 32'(got_q[i].last), 32'(i == N - 1));
        end
        tick();

        // 5. backpressure with concurrent writes
        got_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        w20 = 1'b0; w25 = 1'b0; n = 0;
        while (got_q.size() < N && n < 600) begin
            ready   = 1'($urandom_range(0, 1));
            rs_addr = 5'($urandom);
            rt_addr = 5'($urandom);
            enable  = 1'b1;
            if (!w20 && got_q.size() > 20) begin
                wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h0000CAFE; w20 = 1'b1;
            end else if (!w25 && d_valid && d_idx == 5'd22) begin
                wr_en = 1'b1; wr_addr = 5'd25; wr_data = 32'h0000BEEF; w25 = 1'b1;
            end else begin
                wr_en = 1'($urandom_range(0, 1)); wr_addr = 5'($urandom_range(0, 19)); wr_data = $urandom;
            end
            tick();
            n++;
        end
        wr_en = 1'b0;
        check("bp_word_count", got_q.size(), N);
        for (int i = 0; i < got_q.size(); i++) check("bp_idx", 32'(got_q[i].idx), 32'(i));
        if (got_q.size() == N) begin
            check("bp_old_r20", got_q[20].data, 32'h154);
            check("bp_new_r25", got_q[25].data, 32'h0000BEEF);
        end
        wait_idle(100);
        tick();

        // 6a. reset in the middle of a dump
        got_q.delete();
        ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(d_valid && d_idx == 5'd10) && n < 100) begin
            tick();
            n++;
        end
        check("abort_reached_idx10", 32'(d_idx), 10);
        rst_n = 1'b0; wr_en = 1'b0; rs_addr = 5'd25; rt_addr = 5'd20;
        #1;
        check("abort_valid", 32'(d_valid), 0);
        check("abort_busy", 32'(d_busy), 0);
        check("abort_rs", rs_data, 0);
        check("abort_rt", rt_data, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("abort_no_more_words", got_q.size(), 10);

        // 6b. START while busy is ignored; a later START restarts at 0
        got_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(d_valid && d_idx == 5'd5) && n < 100) begin
            tick();
            n++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_words(N, 200);
        for (int i = 0; i < got_q.size(); i++) check("retrig_idx", 32'(got_q[i].idx), 32'(i));
        wait_idle(50);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #1;
        check("restart_valid", 32'(d_valid), 1);
        check("restart_idx", 32'(d_idx), 0);
        wait_idle(200);

        // 7. fully random traffic
        for (int c = 0; c < 600; c++) begin
            rs_addr = 5'($urandom);
            rt_addr = 5'($urandom);
            enable  = ($urandom_range(0, 3) != 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 5'($urandom);
            wr_data = $urandom;
            start   = ($urandom_range(0, 19) == 0);
            ready   = 1'($urandom_range(0, 1));
            tick();
        end
        wait_idle(400);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
